// File: rtl/if_prefetch_pkg.sv
// Shared constants and types for the prefetching instruction-fetch stage.
// Holds the architecture width, the halt/NOP encodings and the output-action decode.
package if_prefetch_pkg;

    localparam int ARQUITECTURE_BITS = 32;
    localparam logic [ARQUITECTURE_BITS-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [ARQUITECTURE_BITS-1:0] NOP_WORD          = 32'h0000_0000;

    typedef enum logic [2:0] {
        ACT_HOLD     = 3'd0,
        ACT_CLEAR    = 3'd1,
        ACT_REDIRECT = 3'd2,
        ACT_FLUSH    = 3'd3,
        ACT_POP      = 3'd4,
        ACT_STARVE   = 3'd5
    } out_act_e;

    // Clear beats everything and ignores enable; the rest only act while advancing.
    function automatic out_act_e select_action(
        input logic clear,
        input logic advance,
        input logic redirect,
        input logic flush,
        input logic q_empty
    );
        out_act_e act;
        if (clear) begin
            act = ACT_CLEAR;
        end else if (!advance) begin
            act = ACT_HOLD;
        end else if (redirect) begin
            act = ACT_REDIRECT;
        end else if (flush) begin
            act = ACT_FLUSH;
        end else if (q_empty) begin
            act = ACT_STARVE;
        end else begin
            act = ACT_POP;
        end
        return act;
    endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// Pipeline-side bus of the fetch stage: control, memory load port and IF/ID outputs.
interface if_prefetch_if #(
    parameter int PC_SIZE = if_prefetch_pkg::ARQUITECTURE_BITS
);
    logic               i_enable;
    logic               i_halt;
    logic               i_not_load;
    logic               i_flush;
    logic               i_next_pc_src;
    logic [PC_SIZE-1:0] i_next_not_seq_pc;
    logic               i_write_mem;
    logic [PC_SIZE-1:0] i_instruction;
    logic               i_clear_mem;
    logic               o_full_mem;
    logic               o_empty_mem;
    logic               o_queue_empty;
    logic               o_valid;
    logic               o_halt_fetched;
    logic [PC_SIZE-1:0] o_instruction;
    logic [PC_SIZE-1:0] o_next_seq_pc;

    modport master (
        output i_enable, i_halt, i_not_load, i_flush, i_next_pc_src, i_next_not_seq_pc,
               i_write_mem, i_instruction, i_clear_mem,
        input  o_full_mem, o_empty_mem, o_queue_empty, o_valid, o_halt_fetched,
               o_instruction, o_next_seq_pc
    );

    modport slave (
        input  i_enable, i_halt, i_not_load, i_flush, i_next_pc_src, i_next_not_seq_pc,
               i_write_mem, i_instruction, i_clear_mem,
        output o_full_mem, o_empty_mem, o_queue_empty, o_valid, o_halt_fetched,
               o_instruction, o_next_seq_pc
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Synchronous FIFO of {instruction, seq_pc} entries between fetch and the IF/ID register.
// Clear has priority over push and pop; push is accepted on a full queue when a pop frees a slot.
module if_prefetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] slot_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop && !empty && !clear;
    assign do_push_s = push && (!full || do_pop_s) && !clear;
    assign head_data = slot_r[rd_ptr_r[AW-1:0]];

    // Entry storage; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            slot_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage with loadable memory, run-ahead fetch PC and a prefetch queue
// feeding a registered IF/ID output; stops fetching once the halt word has been delivered.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int                 PC_SIZE            = ARQUITECTURE_BITS,
    parameter int                 WORD_SIZE_IN_BYTES = 4,
    parameter int                 MEM_SIZE_IN_WORDS  = 64,
    parameter int                 QUEUE_DEPTH        = 4,
    parameter logic [PC_SIZE-1:0] HALT_WORD          = PC_SIZE'(HALT_WORD_DEFAULT)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    if_prefetch_if.slave  bus
);
    localparam int WB_LOG  = $clog2(WORD_SIZE_IN_BYTES);
    localparam int IDX_W   = $clog2(MEM_SIZE_IN_WORDS);
    localparam int LP_W    = IDX_W + 1;
    localparam int ENTRY_W = 2 * PC_SIZE;
    localparam logic [LP_W-1:0]    LP_MAX  = LP_W'(MEM_SIZE_IN_WORDS);
    localparam logic [LP_W-1:0]    LP_ONE  = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [LP_W-1:0]    LP_ZERO = {LP_W{1'b0}};
    localparam logic [PC_SIZE-1:0] PC_STEP = PC_SIZE'(WORD_SIZE_IN_BYTES);
    localparam logic [PC_SIZE-1:0] PC_ZERO = {PC_SIZE{1'b0}};
    localparam logic [PC_SIZE-1:0] NOP     = PC_SIZE'(NOP_WORD);

    logic [PC_SIZE-1:0] mem_r [MEM_SIZE_IN_WORDS];
    logic [LP_W-1:0]    load_ptr_r;
    logic [PC_SIZE-1:0] fetch_pc_r;
    logic [PC_SIZE-1:0] instr_r;
    logic [PC_SIZE-1:0] seq_pc_r;
    logic               valid_r;
    logic               halt_fetched_r;

    logic               advance_s;
    logic               mem_full_s;
    logic               write_ok_s;
    logic               fetchable_s;
    logic               push_s;
    logic               pop_s;
    logic               q_clear_s;
    logic               q_full_s;
    logic               q_empty_s;
    logic [PC_SIZE-1:0] fetch_word_s;
    logic [IDX_W-1:0]   fetch_idx_s;
    logic [ENTRY_W-1:0] push_data_s;
    logic [ENTRY_W-1:0] head_s;
    logic [PC_SIZE-1:0] head_instr_s;
    logic [PC_SIZE-1:0] head_seq_s;
    out_act_e           act_s;

    // The word index drops the byte-offset bits; anything at or past load_ptr is not yet loaded.
    assign mem_full_s   = (load_ptr_r == LP_MAX);
    assign write_ok_s   = bus.i_write_mem && !mem_full_s && !bus.i_clear_mem;
    assign fetch_word_s = fetch_pc_r >> WB_LOG;
    assign fetch_idx_s  = fetch_word_s[IDX_W-1:0];
    assign fetchable_s  = (fetch_word_s < PC_SIZE'(load_ptr_r));
    assign push_data_s  = {mem_r[fetch_idx_s], fetch_pc_r + PC_STEP};
    assign head_instr_s = head_s[ENTRY_W-1:PC_SIZE];
    assign head_seq_s   = head_s[PC_SIZE-1:0];

    // Per-cycle action decode and the queue controls it implies.
    always_comb begin
        advance_s = bus.i_enable && !bus.i_halt && !bus.i_not_load;
        act_s     = select_action(bus.i_clear_mem, advance_s, bus.i_next_pc_src,
                                  bus.i_flush, q_empty_s);
        pop_s     = (act_s == ACT_POP);
        q_clear_s = (act_s == ACT_CLEAR) || (act_s == ACT_REDIRECT);
        push_s    = fetchable_s && !halt_fetched_r && !q_clear_s && (!q_full_s || pop_s);
    end

    if_prefetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (i_clk),
        .rst_n     (i_reset_n),
        .clear     (q_clear_s),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (push_data_s),
        .head_data (head_s),
        .full      (q_full_s),
        .empty     (q_empty_s)
    );

    // Instruction memory, appended through the load port and deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (write_ok_s) begin
            mem_r[load_ptr_r[IDX_W-1:0]] <= bus.i_instruction;
        end
    end

    // Load pointer: counts words written, saturating at the memory size.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            load_ptr_r <= LP_ZERO;
        end else if (bus.i_clear_mem) begin
            load_ptr_r <= LP_ZERO;
        end else if (write_ok_s) begin
            load_ptr_r <= load_ptr_r + LP_ONE;
        end else begin
            load_ptr_r <= load_ptr_r;
        end
    end

    // Fetch PC runs ahead of the output; redirects retarget it directly.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fetch_pc_r <= PC_ZERO;
        end else if (act_s == ACT_CLEAR) begin
            fetch_pc_r <= PC_ZERO;
        end else if (act_s == ACT_REDIRECT) begin
            fetch_pc_r <= bus.i_next_not_seq_pc;
        end else if (push_s) begin
            fetch_pc_r <= fetch_pc_r + PC_STEP;
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    // IF/ID output register; bubbles keep the last sequential PC.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            instr_r        <= NOP;
            seq_pc_r       <= PC_ZERO;
            valid_r        <= 1'b0;
            halt_fetched_r <= 1'b0;
        end else begin
            case (act_s)
                ACT_CLEAR: begin
                    instr_r        <= NOP;
                    seq_pc_r       <= PC_ZERO;
                    valid_r        <= 1'b0;
                    halt_fetched_r <= 1'b0;
                end
                ACT_REDIRECT: begin
                    instr_r        <= NOP;
                    valid_r        <= 1'b0;
                    halt_fetched_r <= 1'b0;
                end
                ACT_FLUSH, ACT_STARVE: begin
                    instr_r <= NOP;
                    valid_r <= 1'b0;
                end
                ACT_POP: begin
                    instr_r        <= head_instr_s;
                    seq_pc_r       <= head_seq_s;
                    valid_r        <= 1'b1;
                    halt_fetched_r <= halt_fetched_r || (head_instr_s == HALT_WORD);
                end
                default: begin
                    instr_r <= instr_r;
                end
            endcase
        end
    end

    assign bus.o_instruction  = instr_r;
    assign bus.o_next_seq_pc  = seq_pc_r;
    assign bus.o_valid        = valid_r;
    assign bus.o_halt_fetched = halt_fetched_r;
    assign bus.o_full_mem     = mem_full_s;
    assign bus.o_empty_mem    = (load_ptr_r == LP_ZERO);
    assign bus.o_queue_empty  = q_empty_s;

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: load/stream, stall refill, redirect, limits, halt and reset.
module tb_if_prefetch;
    import if_prefetch_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] w [41];

    always #5 clk = ~clk;

    if_prefetch_if #(.PC_SIZE(32)) bus ();

    if_prefetch #(
        .PC_SIZE            (32),
        .WORD_SIZE_IN_BYTES (4),
        .MEM_SIZE_IN_WORDS  (64),
        .QUEUE_DEPTH        (4)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] instr, input logic [31:0] seq, input logic valid);
        chk({tag, "_instr"}, bus.o_instruction, instr);
        chk({tag, "_seq"}, bus.o_next_seq_pc, seq);
        chk1({tag, "_valid"}, bus.o_valid, valid);
    endtask

    initial begin
        bus.i_enable          = 1'b0;
        bus.i_halt            = 1'b0;
        bus.i_not_load        = 1'b0;
        bus.i_flush           = 1'b0;
        bus.i_next_pc_src     = 1'b0;
        bus.i_next_not_seq_pc = 32'h0;
        bus.i_write_mem       = 1'b0;
        bus.i_instruction     = 32'h0;
        bus.i_clear_mem       = 1'b0;
        for (int i = 0; i < 40; i++) begin
            w[i] = $urandom();
            if (w[i] == 32'hFFFF_FFFF) w[i] = 32'h0000_0001;
        end
        w[40] = 32'hFFFF_FFFF;

        // Reset state
        #12;
        chk_out("reset", 32'h0, 32'h0, 1'b0);
        chk1("reset_halt", bus.o_halt_fetched, 1'b0);
        chk1("reset_empty_mem", bus.o_empty_mem, 1'b1);
        chk1("reset_full_mem", bus.o_full_mem, 1'b0);
        chk1("reset_q_empty", bus.o_queue_empty, 1'b1);
        rst_n = 1'b1;

        // Load 40 words plus the halt word while disabled
        for (int i = 0; i < 41; i++) begin
            bus.i_write_mem   = 1'b1;
            bus.i_instruction = w[i];
            step();
            if (i == 0) chk1("load_empty_mem", bus.o_empty_mem, 1'b0);
        end
        bus.i_write_mem = 1'b0;
        chk1("load_full_mem", bus.o_full_mem, 1'b0);
        chk1("load_q_prefilled", bus.o_queue_empty, 1'b0);
        chk_out("load_idle", 32'h0, 32'h0, 1'b0);

        // Stream first ten words
        bus.i_enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk_out("stream_a", w[k], 32'(4 * k + 4), 1'b1);
        end

        // Stall from ID for six cycles
        bus.i_not_load = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk_out("stall_hold", w[9], 32'd40, 1'b1);
            chk1("stall_q_nonempty", bus.o_queue_empty, 1'b0);
        end
        bus.i_not_load = 1'b0;

        // Remaining words, gap-free, ending with the halt word
        for (int k = 10; k < 41; k++) begin
            step();
            chk_out("stream_b", w[k], 32'(4 * k + 4), 1'b1);
            chk1("stream_b_halt", bus.o_halt_fetched, k == 40);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out("after_halt", 32'h0, 32'hA4, 1'b0);
            chk1("after_halt_flag", bus.o_halt_fetched, 1'b1);
            chk1("after_halt_q_empty", bus.o_queue_empty, 1'b1);
        end

        // Redirect to PC 20
        bus.i_next_pc_src     = 1'b1;
        bus.i_next_not_seq_pc = 32'd20;
        step();
        bus.i_next_pc_src = 1'b0;
        chk_out("redir_n", 32'h0, 32'hA4, 1'b0);
        chk1("redir_n_halt_cleared", bus.o_halt_fetched, 1'b0);
        chk1("redir_n_q_empty", bus.o_queue_empty, 1'b1);
        step();
        chk1("redir_n1_valid", bus.o_valid, 1'b0);
        chk1("redir_n1_q_pushed", bus.o_queue_empty, 1'b0);
        step();
        chk_out("redir_n2", w[5], 32'd24, 1'b1);
        step();
        chk_out("redir_n3", w[6], 32'd28, 1'b1);

        // Debug halt: output frozen while the queue refills
        bus.i_halt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_out("dbg_halt_hold", w[6], 32'd28, 1'b1);
        end
        bus.i_halt = 1'b0;
        for (int k = 7; k < 12; k++) begin
            step();
            chk_out("dbg_halt_release", w[k], 32'(4 * k + 4), 1'b1);
        end

        // Enable low: output frozen
        bus.i_enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_out("disable_hold", w[11], 32'd48, 1'b1);
        end
        bus.i_enable = 1'b1;
        step();
        chk_out("enable_resume", w[12], 32'd52, 1'b1);

        // Redirect together with flush: redirect wins and clears the queue
        bus.i_next_pc_src     = 1'b1;
        bus.i_next_not_seq_pc = 32'd0;
        bus.i_flush           = 1'b1;
        step();
        bus.i_next_pc_src = 1'b0;
        bus.i_flush       = 1'b0;
        chk_out("redir_flush_n", 32'h0, 32'd52, 1'b0);
        chk1("redir_flush_q_empty", bus.o_queue_empty, 1'b1);
        step();
        chk1("redir_flush_n1_valid", bus.o_valid, 1'b0);
        step();
        chk_out("redir_flush_n2", w[0], 32'd4, 1'b1);
        step();
        chk_out("redir_flush_n3", w[1], 32'd8, 1'b1);

        // Plain flush: bubble, then no instruction lost
        bus.i_flush = 1'b1;
        step();
        bus.i_flush = 1'b0;
        chk_out("flush_bubble", 32'h0, 32'd8, 1'b0);
        step();
        chk_out("flush_next", w[2], 32'd12, 1'b1);

        // Clear memory
        bus.i_clear_mem = 1'b1;
        step();
        bus.i_clear_mem = 1'b0;
        chk_out("clear", 32'h0, 32'h0, 1'b0);
        chk1("clear_empty_mem", bus.o_empty_mem, 1'b1);
        chk1("clear_q_empty", bus.o_queue_empty, 1'b1);
        chk1("clear_halt", bus.o_halt_fetched, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out("clear_bubbles", 32'h0, 32'h0, 1'b0);
            chk1("clear_no_fetch", bus.o_queue_empty, 1'b1);
        end

        // Fill memory to capacity; the extra write is ignored
        bus.i_enable = 1'b0;
        for (int i = 0; i < 64; i++) begin
            bus.i_write_mem   = 1'b1;
            bus.i_instruction = 32'hA500_0000 + 32'(i);
            step();
        end
        chk1("fill_full_mem", bus.o_full_mem, 1'b1);
        chk1("fill_empty_mem", bus.o_empty_mem, 1'b0);
        bus.i_instruction = 32'hDEAD_BEEF;
        step();
        bus.i_write_mem = 1'b0;
        chk1("overfill_full_mem", bus.o_full_mem, 1'b1);
        bus.i_enable          = 1'b1;
        bus.i_next_pc_src     = 1'b1;
        bus.i_next_not_seq_pc = 32'd0;
        step();
        bus.i_next_pc_src = 1'b0;
        step();
        step();
        chk_out("full_word0_intact", 32'hA500_0000, 32'd4, 1'b1);
        step();
        chk_out("full_word1", 32'hA500_0001, 32'd8, 1'b1);
        step();
        chk_out("full_word2", 32'hA500_0002, 32'd12, 1'b1);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 32'h0, 32'h0, 1'b0);
        chk1("async_rst_q_empty", bus.o_queue_empty, 1'b1);
        chk1("async_rst_empty_mem", bus.o_empty_mem, 1'b1);
        step();
        rst_n             = 1'b1;
        bus.i_write_mem   = 1'b1;
        bus.i_instruction = 32'h1234_5678;
        step();
        bus.i_instruction = 32'h8765_4321;
        chk1("post_rst_e1_q_empty", bus.o_queue_empty, 1'b1);
        chk1("post_rst_e1_valid", bus.o_valid, 1'b0);
        step();
        bus.i_write_mem = 1'b0;
        chk1("post_rst_e2_q_pushed", bus.o_queue_empty, 1'b0);
        chk1("post_rst_e2_valid", bus.o_valid, 1'b0);
        step();
        chk_out("post_rst_e3", 32'h1234_5678, 32'd4, 1'b1);
        step();
        chk_out("post_rst_e4", 32'h8765_4321, 32'd8, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
